// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises and edge-detects IRQ lines, latches pending flags, and drives REQ/ADDR_INT until RTI.
// Optional non-maskable source is enabled by defining INT_NMI_EN.
module int_ctrl #(
    parameter int          NUM_IRQ  = 8,
    parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_IRQ-1:0] IRQ_IN,
    input  logic               IE_WE,
    input  logic [NUM_IRQ-1:0] IE_DIN,
    input  logic [NUM_IRQ-1:0] IFG_CLR,
    input  logic               GIE,
    input  logic               RTI,
`ifdef INT_NMI_EN
    input  logic               NMI_IN,
`endif
    output logic               REQ,
    output logic [15:0]        ADDR_INT,
    output logic [NUM_IRQ-1:0] IFG,
    output logic [NUM_IRQ-1:0] IE,
    output logic               BUSY,
    output logic [1:0]         STATE_DBG
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVICE = 2'd1,
        S_GAP     = 2'd2
    } state_t;

`ifdef INT_NMI_EN
    localparam int NL = NUM_IRQ + 1;
    logic [NL-1:0] lines;
    assign lines = {NMI_IN, IRQ_IN};
`else
    localparam int NL = NUM_IRQ;
    logic [NL-1:0] lines;
    assign lines = IRQ_IN;
`endif

    state_t             state_q, state_d;
    logic [NL-1:0]      s1_q, s2_q, prev_q, evt;
    logic [NUM_IRQ-1:0] ie_q, ie_d, ifg_q, ifg_d;
    logic [NUM_IRQ-1:0] elig, sel_onehot, disp_clr;
    logic [3:0]         sel_id;
    logic               dispatch;
    logic               req_q, req_d, busy_q, busy_d;
    logic [15:0]        addr_q, addr_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= lines;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign evt = s2_q & ~prev_q;

    // A new event wins over any clear landing in the same cycle.
    assign ie_d  = IE_WE ? IE_DIN : ie_q;
    assign ifg_d = (ifg_q & ~IFG_CLR & ~disp_clr) | evt[NUM_IRQ-1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ie_q  <= '0;
            ifg_q <= '0;
        end else begin
            ie_q  <= ie_d;
            ifg_q <= ifg_d;
        end
    end

`ifdef INT_NMI_EN
    logic nmifg_q, nmifg_d;
    assign nmifg_d = evt[NUM_IRQ] | (nmifg_q & ~dispatch);
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) nmifg_q <= 1'b0;
        else       nmifg_q <= nmifg_d;
    end
`endif

    // Highest index wins; the NMI pseudo-id 14 overrides every maskable source.
    always_comb begin
        elig       = ifg_q & ie_q & {NUM_IRQ{GIE}};
        sel_id     = 4'd0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (elig[i]) begin
                sel_id        = 4'(i);
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
        dispatch = (state_q == S_IDLE) && (|elig);
`ifdef INT_NMI_EN
        if (nmifg_q) begin
            sel_id     = 4'd14;
            sel_onehot = '0;
            dispatch   = (state_q == S_IDLE);
        end
`endif
        disp_clr = dispatch ? sel_onehot : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (dispatch) state_d = S_SERVICE;
            S_SERVICE: if (RTI)      state_d = S_GAP;
            S_GAP:                   state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_d  = (state_d == S_SERVICE);
        busy_d = (state_d != S_IDLE);
        addr_d = dispatch ? (VEC_BASE + {11'b0, sel_id, 1'b0}) : addr_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
        end
    end

    assign REQ       = req_q;
    assign BUSY      = busy_q;
    assign ADDR_INT  = addr_q;
    assign IFG       = ifg_q;
    assign IE        = ie_q;
    assign STATE_DBG = state_q;

endmodule
